gf180mcu_osu_sc_gp9t3v3__tbus_ctrl: RTL and testbench

GF180MCU_OSU_SC_GP9T3V3__TBUS_CTRL -- requirements
Module: gf180mcu_osu_sc_gp9t3v3__tbus_ctrl

---
 rtl/gf180mcu_osu_sc_gp9t3v3__tbus_ctrl.sv | 163 ++++++++++++++++
 tb/tb_gf180mcu_osu_sc_gp9t3v3__tbus_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_osu_sc_gp9t3v3__tbus_ctrl.sv
// Shared tri-state bus controller: round-robin owner selection with
// break-before-make dead time between owners and an optional hold limit.
module gf180mcu_osu_sc_gp9t3v3__tbus_ctrl #(
    parameter int WIDTH   = 8,
    parameter int NCH     = 4,
    parameter int DEAD    = 2,
    parameter int MAXHOLD = 16
) (
    input  logic                   CLK,
    input  logic                   RN,
    input  logic [NCH-1:0]         REQ,
    input  logic [NCH*WIDTH-1:0]   A,
    output logic [NCH-1:0]         GNT,
    output logic [NCH-1:0]         EN,
    output logic [NCH-1:0]         EN_BAR,
    output logic [WIDTH-1:0]       Y,
    output logic                   BUSY
);

    localparam int PW = $clog2(NCH);
    localparam int HW = (MAXHOLD < 2) ? 1 : $clog2(MAXHOLD + 1);
    localparam logic [HW-1:0] MH      = HW'(MAXHOLD);
    localparam logic [3:0]    DEAD_LD = 4'(DEAD);

    generate
        if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
            $error("WIDTH out of range");
        end
        if (NCH < 2 || NCH > 16) begin : g_bad_nch
            $error("NCH out of range");
        end
        if (DEAD < 1 || DEAD > 15) begin : g_bad_dead
            $error("DEAD out of range");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DEAD_ST = 2'd2
    } state_t;

    state_t          state_q;
    logic [NCH-1:0]  en_q;
    logic [NCH-1:0]  en_bar_q;
    logic [NCH-1:0]  gnt_q;
    logic            busy_q;
    logic [PW-1:0]   ptr_q;
    logic [HW-1:0]   hold_q;
    logic [3:0]      dead_q;

    logic [NCH-1:0]  grant_d;
    logic [PW-1:0]   ptr_d;
    logic [HW-1:0]   hold_d;
    logic            any_req;
    logic            owner_req;
    logic            others_req;
    logic            release_d;
    logic [WIDTH-1:0] y_mux;

    // Rotating search from ptr_q; ptr_q always holds last owner + 1.
    always_comb begin
        int  idx;
        logic found;
        grant_d = '0;
        ptr_d   = ptr_q;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NCH; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NCH) idx = idx - NCH;
            if (!found && REQ[idx]) begin
                found        = 1'b1;
                grant_d[idx] = 1'b1;
                ptr_d        = PW'((idx + 1) % NCH);
            end
        end
    end

    assign any_req    = |REQ;
    assign owner_req  = |(REQ & gnt_q);
    assign others_req = |(REQ & ~gnt_q);
    assign hold_d     = (hold_q == MH) ? hold_q : hold_q + 1'b1;
    assign release_d  = !owner_req ||
                        ((MAXHOLD != 0) && (hold_d == MH) && others_req);

    always_ff @(posedge CLK) begin
        if (!RN) begin
            state_q  <= IDLE;
            en_q     <= '0;
            en_bar_q <= '1;
            gnt_q    <= '0;
            busy_q   <= 1'b0;
            ptr_q    <= '0;
            hold_q   <= '0;
            dead_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q  <= DRIVE;
                        en_q     <= grant_d;
                        en_bar_q <= ~grant_d;
                        gnt_q    <= grant_d;
                        busy_q   <= 1'b1;
                        ptr_q    <= ptr_d;
                        hold_q   <= '0;
                    end
                end
                DRIVE: begin
                    hold_q <= hold_d;
                    if (release_d) begin
                        state_q  <= DEAD_ST;
                        en_q     <= '0;
                        en_bar_q <= '1;
                        gnt_q    <= '0;
                        dead_q   <= DEAD_LD;
                    end
                end
                DEAD_ST: begin
                    if (dead_q > 4'd1) begin
                        dead_q <= dead_q - 4'd1;
                    end else begin
                        dead_q <= '0;
                        // Requests are re-sampled here; anyone who dropped during dead time loses.
                        if (any_req) begin
                            state_q  <= DRIVE;
                            en_q     <= grant_d;
                            en_bar_q <= ~grant_d;
                            gnt_q    <= grant_d;
                            ptr_q    <= ptr_d;
                            hold_q   <= '0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    en_q     <= '0;
                    en_bar_q <= '1;
                    gnt_q    <= '0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        y_mux = '0;
        for (int i = 0; i < NCH; i++) begin
            if (en_q[i]) y_mux = y_mux | A[i*WIDTH +: WIDTH];
        end
    end

    assign Y      = (|en_q) ? y_mux : {WIDTH{1'bz}};
    assign EN     = en_q;
    assign EN_BAR = en_bar_q;
    assign GNT    = gnt_q;
    assign BUSY   = busy_q;

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp9t3v3__tbus_ctrl.sv
// Directed bench for the tri-state bus controller (NCH=4, WIDTH=8, DEAD=2, MAXHOLD=4).
module tb_gf180mcu_osu_sc_gp9t3v3__tbus_ctrl;

    logic        CLK;
    logic        RN;
    logic [3:0]  REQ;
    logic [31:0] A;
    wire  [3:0]  GNT;
    wire  [3:0]  EN;
    wire  [3:0]  EN_BAR;
    wire  [7:0]  Y;
    wire         BUSY;

    int checks = 0;
    int errors = 0;
    logic mon_on = 1'b0;

    gf180mcu_osu_sc_gp9t3v3__tbus_ctrl #(
        .WIDTH(8), .NCH(4), .DEAD(2), .MAXHOLD(4)
    ) dut (
        .CLK(CLK), .RN(RN), .REQ(REQ), .A(A),
        .GNT(GNT), .EN(EN), .EN_BAR(EN_BAR), .Y(Y), .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Structural invariants checked every cycle once reset has been applied.
    always @(negedge CLK) begin
        if (mon_on) begin
            if (EN !== ~EN_BAR) begin
                errors++;
                $display("FAIL en_complement: EN=%b EN_BAR=%b", EN, EN_BAR);
            end
            checks++;
            if (!$onehot0(EN)) begin
                errors++;
                $display("FAIL en_onehot0: EN=%b", EN);
            end
            checks++;
            if (EN !== GNT) begin
                errors++;
                $display("FAIL en_eq_gnt: EN=%b GNT=%b", EN, GNT);
            end
            checks++;
        end
    end

    task automatic do_reset;
        RN  = 1'b0;
        REQ = 4'b0000;
        tick();
        tick();
        RN = 1'b1;
    endtask

    task automatic test_reset;
        RN  = 1'b0;
        REQ = 4'b0000;
        tick();
        tick();
        mon_on = 1'b1;
        if (EN !== 4'b0000 || EN_BAR !== 4'b1111 || GNT !== 4'b0000 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset: EN=%b EN_BAR=%b GNT=%b BUSY=%b expected 0000 1111 0000 0", EN, EN_BAR, GNT, BUSY);
        end
        checks++;
        RN = 1'b1;
        tick();
        if (EN !== 4'b0000 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: EN=%b BUSY=%b expected 0000 0", EN, BUSY);
        end
        checks++;
        $display("reset: EN=%b EN_BAR=%b GNT=%b BUSY=%b", EN, EN_BAR, GNT, BUSY);
    endtask

    task automatic test_single_grant;
        REQ = 4'b0100;
        tick();
        if (EN !== 4'b0100 || EN_BAR !== 4'b1011 || GNT !== 4'b0100) begin
            errors++;
            $display("FAIL grant_ch2: EN=%b EN_BAR=%b GNT=%b expected 0100 1011 0100", EN, EN_BAR, GNT);
        end
        checks++;
        if (Y !== 8'hA5 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL grant_ch2_bus: Y=%h BUSY=%b expected a5 1", Y, BUSY);
        end
        checks++;
        $display("single grant: REQ=%b EN=%b Y=%h BUSY=%b", REQ, EN, Y, BUSY);
    endtask

    task automatic test_handover;
        REQ = 4'b0001;
        for (int c = 0; c < 2; c++) begin
            tick();
            if (EN !== 4'b0000 || BUSY !== 1'b1) begin
                errors++;
                $display("FAIL handover_dead%0d: EN=%b BUSY=%b expected 0000 1", c, EN, BUSY);
            end
            checks++;
        end
        tick();
        if (EN !== 4'b0001 || Y !== 8'h11) begin
            errors++;
            $display("FAIL handover_grant: EN=%b Y=%h expected 0001 11", EN, Y);
        end
        checks++;
        REQ = 4'b0000;
        tick();
        tick();
        if (BUSY !== 1'b1 || EN !== 4'b0000) begin
            errors++;
            $display("FAIL release_dead: EN=%b BUSY=%b expected 0000 1", EN, BUSY);
        end
        checks++;
        tick();
        if (BUSY !== 1'b0 || EN !== 4'b0000) begin
            errors++;
            $display("FAIL release_idle: EN=%b BUSY=%b expected 0000 0", EN, BUSY);
        end
        checks++;
        $display("handover: 0100 -> dead x2 -> 0001 -> idle");
    endtask

    task automatic test_round_robin;
        logic [3:0] exp;
        logic [7:0] exp_y;
        do_reset();
        REQ = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            exp   = 4'b0001 << (g % 4);
            exp_y = 8'h11 * 8'((g % 4) + 1);
            if ((g % 4) == 2) exp_y = 8'hA5;
            for (int c = 0; c < 4; c++) begin
                tick();
                if (EN !== exp || Y !== exp_y) begin
                    errors++;
                    $display("FAIL rr_grant%0d_cyc%0d: EN=%b Y=%h expected %b %h", g, c, EN, Y, exp, exp_y);
                end
                checks++;
            end
            if (g < 4) begin
                for (int c = 0; c < 2; c++) begin
                    tick();
                    if (EN !== 4'b0000) begin
                        errors++;
                        $display("FAIL rr_dead%0d_cyc%0d: EN=%b expected 0000", g, c, EN);
                    end
                    checks++;
                end
            end
            $display("round robin: grant %0d EN=%b", g, exp);
        end
    endtask

    task automatic test_single_hold;
        do_reset();
        REQ = 4'b0010;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (EN !== 4'b0010) begin
                errors++;
                $display("FAIL single_hold_cyc%0d: EN=%b expected 0010", c, EN);
            end
            checks++;
        end
        $display("single hold: EN=%b after 20 cycles", EN);
    endtask

    task automatic test_late_contender;
        do_reset();
        REQ = 4'b0100;
        for (int c = 0; c < 7; c++) tick();
        REQ = 4'b0101;
        tick();
        if (EN !== 4'b0000) begin
            errors++;
            $display("FAIL late_contender_release: EN=%b expected 0000", EN);
        end
        checks++;
        tick();
        tick();
        if (EN !== 4'b0001 || Y !== 8'h11) begin
            errors++;
            $display("FAIL late_contender_grant: EN=%b Y=%h expected 0001 11", EN, Y);
        end
        checks++;
        $display("late contender: saturated owner 2 released, EN=%b", EN);
    endtask

    task automatic test_reset_mid_drive;
        do_reset();
        REQ = 4'b1000;
        tick();
        tick();
        if (EN !== 4'b1000) begin
            errors++;
            $display("FAIL mid_drive_setup: EN=%b expected 1000", EN);
        end
        checks++;
        RN = 1'b0;
        tick();
        if (EN !== 4'b0000 || GNT !== 4'b0000 || BUSY !== 1'b0 || EN_BAR !== 4'b1111) begin
            errors++;
            $display("FAIL mid_drive_reset: EN=%b GNT=%b BUSY=%b EN_BAR=%b expected 0000 0000 0 1111", EN, GNT, BUSY, EN_BAR);
        end
        checks++;
        RN  = 1'b1;
        REQ = 4'b1001;
        tick();
        if (EN !== 4'b0001) begin
            errors++;
            $display("FAIL post_reset_grant: EN=%b expected 0001", EN);
        end
        checks++;
        $display("reset mid drive: post-reset EN=%b", EN);
    endtask

    task automatic test_drop_during_dead;
        REQ = 4'b0010;
        tick();
        REQ = 4'b0100;
        tick();
        if (EN !== 4'b0000) begin
            errors++;
            $display("FAIL drop_dead: EN=%b expected 0000", EN);
        end
        checks++;
        tick();
        if (EN !== 4'b0100 || Y !== 8'hA5) begin
            errors++;
            $display("FAIL drop_dead_grant: EN=%b Y=%h expected 0100 a5", EN, Y);
        end
        checks++;
        $display("drop during dead: ch1 skipped, EN=%b", EN);
    endtask

    initial begin
        RN  = 1'b0;
        REQ = 4'b0000;
        A   = {8'h44, 8'hA5, 8'h22, 8'h11};
        test_reset();
        test_single_grant();
        test_handover();
        test_round_robin();
        test_single_hold();
        test_late_contender();
        test_reset_mid_drive();
        test_drop_during_dead();
        mon_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
